// File: rtl/edge_pattern_gen_if.sv
// Command channel for edge_pattern_gen: a level and a hold time under valid/ready.
interface edge_pattern_gen_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_level;
    logic [CNT_W-1:0] cmd_hold;

    modport master (output cmd_valid, output cmd_level, output cmd_hold, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_level, input  cmd_hold, output cmd_ready);
endinterface

// File: rtl/edge_pattern_gen.sv
// Drives x_out with commanded levels, each held at least MIN_HOLD cycles,
// and emits rise/fall strobes aligned with every transition.
module edge_pattern_gen #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MIN_HOLD = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    edge_pattern_gen_if.slave   cmd,
    output logic                x_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                hold_clamped,
    output logic                busy
);

    localparam longint unsigned MAX_HOLD = (64'(1) << CNT_W) - 64'(1);

    if (MIN_HOLD < 2 || 64'(MIN_HOLD) > MAX_HOLD) begin : g_param_err
        $error("edge_pattern_gen: MIN_HOLD must lie in 2 .. 2**CNT_W-1");
    end

    // One-hot encoding leaves room for illegal codes, which fall back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             clamp_q, clamp_d;

    logic             short_hold;
    logic [CNT_W-1:0] eff_hold;

    assign short_hold = (cmd.cmd_hold < CNT_W'(MIN_HOLD));
    assign eff_hold   = short_hold ? CNT_W'(MIN_HOLD) : cmd.cmd_hold;

    // Next-state and output logic; strobes default low every cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        clamp_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    x_d     = cmd.cmd_level;
                    rise_d  = cmd.cmd_level & ~x_q;
                    fall_d  = ~cmd.cmd_level & x_q;
                    clamp_d = short_hold;
                    cnt_d   = eff_hold - CNT_W'(1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Load is eff_hold-1, so HOLD spans eff_hold-1 cycles.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            clamp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            clamp_q <= clamp_d;
        end
    end

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q == ST_HOLD);
    assign x_out         = x_q;
    assign rise_pulse    = rise_q;
    assign fall_pulse    = fall_q;
    assign hold_clamped  = clamp_q;

endmodule

// File: tb/tb_edge_pattern_gen.sv
// Scoreboard bench for edge_pattern_gen with a loopback edge detector on x_out.
module tb_edge_pattern_gen;

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned MIN_HOLD = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic x_out, rise_pulse, fall_pulse, hold_clamped, busy;

    always #5 clk = ~clk;

    edge_pattern_gen_if #(.CNT_W(CNT_W)) cmd_if ();

    edge_pattern_gen #(.CNT_W(CNT_W), .MIN_HOLD(MIN_HOLD)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd          (cmd_if),
        .x_out        (x_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .hold_clamped (hold_clamped),
        .busy         (busy)
    );

    // Moore edge detector: registered pulse one cycle after each x_out edge.
    logic det_prev, det_rise, det_fall;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            det_prev <= 1'b0;
            det_rise <= 1'b0;
            det_fall <= 1'b0;
        end else begin
            det_prev <= x_out;
            det_rise <= x_out & ~det_prev;
            det_fall <= ~x_out & det_prev;
        end
    end

    typedef struct packed {
        logic x;
        logic rise;
        logic fall;
        logic clamp;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic m_x;
    int   m_left;
    logic prev_rise, prev_fall;
    logic last_acc, seen_ready;
    int   busy_seen, x_high_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_x       = 1'b0;
        m_left    = 0;
        prev_rise = 1'b0;
        prev_fall = 1'b0;
    endtask

    // One clock: drive at negedge, predict, sample #1 after posedge.
    task automatic step(input logic v, input logic lvl, input logic [CNT_W-1:0] hold);
        exp_t e;
        exp_t got;
        int   eff;
        cmd_if.cmd_valid = v;
        cmd_if.cmd_level = lvl;
        cmd_if.cmd_hold  = hold;
        #1;
        check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(m_left == 0));
        seen_ready = cmd_if.cmd_ready;
        last_acc   = v && (m_left == 0);
        e = '0;
        if (last_acc) begin
            eff     = (int'(hold) < int'(MIN_HOLD)) ? int'(MIN_HOLD) : int'(hold);
            e.rise  = lvl & ~m_x;
            e.fall  = ~lvl & m_x;
            e.clamp = (int'(hold) < int'(MIN_HOLD));
            m_x     = lvl;
            m_left  = eff - 1;
        end else if (m_left > 0) begin
            m_left--;
        end
        e.x    = m_x;
        e.busy = (m_left > 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("x_out",        32'(x_out),        32'(got.x));
        check("rise_pulse",   32'(rise_pulse),   32'(got.rise));
        check("fall_pulse",   32'(fall_pulse),   32'(got.fall));
        check("hold_clamped", 32'(hold_clamped), 32'(got.clamp));
        check("busy",         32'(busy),         32'(got.busy));
        check("det_rise",     32'(det_rise),     32'(prev_rise));
        check("det_fall",     32'(det_fall),     32'(prev_fall));
        prev_rise = got.rise;
        prev_fall = got.fall;
        busy_seen   += int'(busy);
        x_high_seen += int'(x_out);
        @(negedge clk);
    endtask

    task automatic send(input logic lvl, input logic [CNT_W-1:0] hold);
        int n;
        n = 0;
        do begin
            step(1'b1, lvl, hold);
            n++;
        end while (!last_acc && n < 400);
        if (!last_acc) check("accept_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int n;
        reset_n          = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_level = 1'b1;
        cmd_if.cmd_hold  = 8'd5;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        // Commands during reset are ignored
        check("rst_x_out", 32'(x_out), 32'(0));
        check("rst_busy",  32'(busy),  32'(0));
        check("rst_rise",  32'(rise_pulse | fall_pulse | hold_clamped), 32'(0));
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'(1));
        cmd_if.cmd_valid = 1'b0;
        reset_n          = 1'b1;

        // Same-level command from reset
        busy_seen = 0; x_high_seen = 0;
        send(1'b0, 8'd4);
        repeat (4) step(1'b0, 1'b0, 8'd0);
        check("same_lvl_busy", 32'(busy_seen), 32'(3));
        check("same_lvl_xhigh", 32'(x_high_seen), 32'(0));

        // Hold 5 high, then 3 low with valid held
        busy_seen = 0; x_high_seen = 0;
        send(1'b1, 8'd5);
        send(1'b0, 8'd3);
        repeat (4) step(1'b0, 1'b0, 8'd0);
        check("h5_xhigh", 32'(x_high_seen), 32'(5));

        // Clamped holds back to back
        x_high_seen = 0;
        send(1'b1, 8'd0);
        send(1'b0, 8'd1);
        repeat (3) step(1'b0, 1'b0, 8'd0);
        check("clamp_xhigh", 32'(x_high_seen), 32'(2));

        // Maximum hold
        busy_seen = 0;
        send(1'b1, 8'd255);
        n = 1;
        while (n < 400) begin
            step(1'b1, 1'b0, 8'd2);
            if (last_acc) break;
            n++;
        end
        check("max_gap", 32'(n), 32'(255));
        check("max_busy", 32'(busy_seen), 32'(255));
        repeat (3) step(1'b0, 1'b0, 8'd0);

        // Reset asserted mid-hold with x_out high
        send(1'b0, 8'd2);
        step(1'b0, 1'b0, 8'd0);
        send(1'b1, 8'd10);
        step(1'b0, 1'b0, 8'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_x",    32'(x_out),      32'(0));
        check("mid_rst_busy", 32'(busy),       32'(0));
        check("mid_rst_fall", 32'(fall_pulse), 32'(0));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        send(1'b1, 8'd3);
        repeat (3) step(1'b0, 1'b0, 8'd0);

        // Random commands with loopback detection
        for (int i = 0; i < 60; i++) begin
            logic             lvl;
            logic [CNT_W-1:0] hold;
            lvl  = 1'($urandom_range(0, 1));
            hold = CNT_W'($urandom_range(2, 20));
            if (i % 10 == 9) hold = CNT_W'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 8'd0);
            send(lvl, hold);
        end
        repeat (25) step(1'b0, 1'b0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
